// File: rtl/data_mem_mmio.sv
// Data-side memory stage for the multi-cycle core.
// A single-port RAM sits at the bottom of the address space. A small MMIO page
// above it holds a transmit FIFO, drained by a valid/ready consumer, and an
// 8-bit free-running timer with sticky wrap and drop flags.
module data_mem_mmio #(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 8,
    parameter int                RAM_DEPTH  = 240,
    parameter logic [ADDR_W-1:0] MMIO_BASE  = 8'hF0,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] dataAddr,
    input  logic [DATA_W-1:0] dataOut,
    input  logic              writeEnable,
    output logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    // FIFO_DEPTH is a power of two (at least 2), so the pointers wrap for free.
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  COUNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] RAM_TOP     = ADDR_W'(RAM_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_TX     = MMIO_BASE;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(MMIO_BASE + 1);
    localparam logic [ADDR_W-1:0] ADDR_TIMER  = ADDR_W'(MMIO_BASE + 2);
    localparam logic [ADDR_W-1:0] ADDR_TCTRL  = ADDR_W'(MMIO_BASE + 3);

    logic [DATA_W-1:0] ram [RAM_DEPTH];
    logic [DATA_W-1:0] fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  count;
    logic              dropFlag;
    logic [7:0]        timer;
    logic              timerEnable;
    logic              wrapFlag;

    logic isRam;
    logic fifoEmpty;
    logic fifoFull;
    logic push;
    logic pop;
    logic pushAccept;
    logic tctrlWrite;
    logic clearCount;
    logic clearWrap;
    logic clearDrop;
    logic wrapSet;

    // Address decode and the FIFO/timer control strobes for this cycle.
    assign isRam      = dataAddr < RAM_TOP;
    assign fifoEmpty  = count == '0;
    assign fifoFull   = count == COUNT_FULL;
    assign pop        = !fifoEmpty && tx_ready;
    assign push       = writeEnable && (dataAddr == ADDR_TX);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign pushAccept = push && (!fifoFull || pop);
    assign tctrlWrite = writeEnable && (dataAddr == ADDR_TCTRL);
    assign clearCount = tctrlWrite && dataOut[1];
    assign clearWrap  = tctrlWrite && dataOut[2];
    assign clearDrop  = tctrlWrite && dataOut[3];
    // A forced clear of the count suppresses the increment, so it cannot wrap.
    assign wrapSet    = timerEnable && (timer == 8'hFF) && !clearCount;

    assign tx_valid = !fifoEmpty;
    assign tx_data  = fifoEmpty ? '0 : fifoMem[rdPtr];

    // Read mux: combinational from the address; same-cycle writes show the old value.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        dataIn = '0;
        if (isRam) begin
            dataIn = ram[dataAddr];
        end else begin
            case (dataAddr)
                ADDR_STATUS: dataIn = DATA_W'({dropFlag, wrapFlag, fifoFull, fifoEmpty});
                ADDR_TIMER:  dataIn = DATA_W'(timer);
                ADDR_TCTRL:  dataIn = DATA_W'(timerEnable);
                default:     dataIn = '0;
            endcase
        end
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are deliberately left out of reset; only the control state that gives them meaning is cleared.
        if (writeEnable && isRam) begin
            ram[dataAddr] <= dataOut;
        end
    end

    // FIFO storage write; the count and pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (pushAccept) begin
            fifoMem[wrPtr] <= dataOut;
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            dropFlag <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples the pre-edge values.
            if (pushAccept) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({pushAccept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (clearDrop) begin
                dropFlag <= 1'b0;
            end else if (push && !pushAccept) begin
                dropFlag <= 1'b1;
            end
        end
    end

    // Timer count, enable level and sticky wrap flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer       <= '0;
            timerEnable <= 1'b0;
            wrapFlag    <= 1'b0;
        end else begin
            if (tctrlWrite) begin
                timerEnable <= dataOut[0];
            end
            if (clearCount) begin
                timer <= '0;
            end else if (timerEnable) begin
                timer <= timer + 8'd1;
            end
            if (clearWrap) begin
                wrapFlag <= 1'b0;
            end else if (wrapSet) begin
                wrapFlag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_data_mem_mmio;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] dataAddr;
    logic [7:0] dataOut;
    logic       writeEnable;
    logic [7:0] dataIn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0] mRam [256];
    bit         mWritten [256];
    logic [7:0] mFifo [$];
    int         mTimer;
    bit         mEn;
    bit         mWrap;
    bit         mDrop;

    always #5 clk = ~clk;

    data_mem_mmio dut (
        .clk         (clk),
        .reset       (reset),
        .dataAddr    (dataAddr),
        .dataOut     (dataOut),
        .writeEnable (writeEnable),
        .dataIn      (dataIn),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] modelRead(input logic [7:0] a);
        if (a < 8'd240) return mRam[a];
        case (a)
            8'hF1:   return {4'b0, mDrop, mWrap, (mFifo.size() == 4), (mFifo.size() == 0)};
            8'hF2:   return mTimer[7:0];
            8'hF3:   return {7'b0, mEn};
            default: return 8'h00;
        endcase
    endfunction

    task automatic modelReset();
        mFifo.delete();
        mTimer = 0;
        mEn    = 1'b0;
        mWrap  = 1'b0;
        mDrop  = 1'b0;
    endtask

    // Apply the current inputs to the model, then let the DUT see one rising edge.
    task automatic tick();
        bit pop;
        bit push;
        bit accept;
        bit tc;
        bit wrapSet;
        pop    = (mFifo.size() > 0) && tx_ready;
        push   = writeEnable && (dataAddr == 8'hF0);
        accept = push && ((mFifo.size() < 4) || pop);
        tc     = writeEnable && (dataAddr == 8'hF3);
        if (pop) void'(mFifo.pop_front());
        if (accept) mFifo.push_back(dataOut);
        if (tc && dataOut[3]) mDrop = 1'b0;
        else if (push && !accept) mDrop = 1'b1;
        wrapSet = 1'b0;
        if (tc && dataOut[1]) begin
            mTimer = 0;
        end else if (mEn) begin
            if (mTimer == 255) wrapSet = 1'b1;
            mTimer = (mTimer + 1) % 256;
        end
        if (tc && dataOut[2]) mWrap = 1'b0;
        else if (wrapSet) mWrap = 1'b1;
        if (tc) mEn = dataOut[0];
        if (writeEnable && dataAddr < 8'd240) begin
            mRam[dataAddr]     = dataOut;
            mWritten[dataAddr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doWrite(input logic [7:0] a, input logic [7:0] d);
        dataAddr    = a;
        dataOut     = d;
        writeEnable = 1'b1;
        tick();
        writeEnable = 1'b0;
    endtask

    task automatic readCheck(input logic [7:0] a, input logic [7:0] expected, input string tag);
        dataAddr    = a;
        writeEnable = 1'b0;
        #1;
        check(tag, dataIn, expected);
    endtask

    task automatic checkAgainstModel(input string tag);
        logic [7:0] expData;
        expData = (mFifo.size() > 0) ? mFifo[0] : 8'h00;
        if (!(dataAddr < 8'd240 && !mWritten[dataAddr]))
            check({tag, "_rd"}, dataIn, modelRead(dataAddr));
        check({tag, "_valid"}, {7'b0, tx_valid}, {7'b0, (mFifo.size() > 0)});
        check({tag, "_data"}, tx_data, expData);
    endtask

    initial begin
        logic [7:0] expFirst [4];
        logic [7:0] expSecond [4];
        logic [7:0] pick;
        expFirst  = '{8'h11, 8'h22, 8'h33, 8'h44};
        expSecond = '{8'hA2, 8'hA3, 8'hA4, 8'h66};

        // Reset state.
        reset       = 1'b1;
        dataAddr    = 8'h00;
        dataOut     = 8'h00;
        writeEnable = 1'b0;
        tx_ready    = 1'b0;
        modelReset();
        #1;
        check("rst_valid", {7'b0, tx_valid}, 8'h00);
        check("rst_data", tx_data, 8'h00);
        readCheck(8'hF1, 8'h01, "rst_status");
        readCheck(8'hF2, 8'h00, "rst_timer");
        readCheck(8'hF3, 8'h00, "rst_tctrl");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // RAM write/read and old-value read during the write cycle.
        doWrite(8'h10, 8'h5A);
        readCheck(8'h10, 8'h5A, "ram_rd");
        dataAddr    = 8'h10;
        dataOut     = 8'hA5;
        writeEnable = 1'b1;
        #1;
        check("ram_old_in_wr_cycle", dataIn, 8'h5A);
        tick();
        writeEnable = 1'b0;
        readCheck(8'h10, 8'hA5, "ram_new");

        // Fill FIFO, overflow, drain.
        tx_ready = 1'b0;
        doWrite(8'hF0, 8'h11);
        doWrite(8'hF0, 8'h22);
        doWrite(8'hF0, 8'h33);
        doWrite(8'hF0, 8'h44);
        readCheck(8'hF1, 8'h02, "status_full");
        check("head_full", tx_data, 8'h11);
        readCheck(8'hF0, 8'h00, "txdata_reads_zero");
        doWrite(8'hF0, 8'h55);
        readCheck(8'hF1, 8'h0A, "status_drop");
        dataAddr = 8'hF1;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", {7'b0, tx_valid}, 8'h01);
            check("drain_data", tx_data, expFirst[i]);
            tick();
        end
        tx_ready = 1'b0;
        readCheck(8'hF1, 8'h09, "status_empty_drop");
        check("drained_data", tx_data, 8'h00);
        doWrite(8'hF3, 8'h08);
        readCheck(8'hF1, 8'h01, "drop_cleared");

        // Push into a full FIFO while the head is popped.
        doWrite(8'hF0, 8'hA1);
        doWrite(8'hF0, 8'hA2);
        doWrite(8'hF0, 8'hA3);
        doWrite(8'hF0, 8'hA4);
        dataAddr    = 8'hF0;
        dataOut     = 8'h66;
        writeEnable = 1'b1;
        tx_ready    = 1'b1;
        #1;
        check("full_pop_head", tx_data, 8'hA1);
        tick();
        writeEnable = 1'b0;
        tx_ready    = 1'b0;
        readCheck(8'hF1, 8'h02, "full_push_pop_no_drop");
        dataAddr = 8'hF1;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain2_data", tx_data, expSecond[i]);
            tick();
        end
        tx_ready = 1'b0;
        check("drain2_empty", {7'b0, tx_valid}, 8'h00);

        // Timer run up to wrap.
        doWrite(8'hF3, 8'h01);
        readCheck(8'hF3, 8'h01, "tctrl_enable");
        dataAddr = 8'hF2;
        repeat (255) tick();
        readCheck(8'hF2, 8'hFF, "timer_ff");
        readCheck(8'hF1, 8'h01, "no_wrap_yet");
        dataAddr = 8'hF2;
        tick();
        readCheck(8'hF2, 8'h00, "timer_wrapped");
        readCheck(8'hF1, 8'h05, "wrap_set");
        doWrite(8'hF3, 8'h05);
        readCheck(8'hF1, 8'h01, "wrap_cleared");
        readCheck(8'hF2, 8'h01, "timer_after_clr_wrap");

        // Clear of wrap on the very edge that wraps the timer wins.
        dataAddr = 8'hF2;
        for (int i = 0; i < 300 && mTimer != 255; i++) tick();
        readCheck(8'hF2, 8'hFF, "timer_ff_again");
        doWrite(8'hF3, 8'h05);
        readCheck(8'hF1, 8'h01, "wrap_clear_priority");
        readCheck(8'hF2, 8'h00, "timer_wrap2");
        doWrite(8'hF3, 8'h03);
        readCheck(8'hF2, 8'h00, "timer_clear_count");
        doWrite(8'hF3, 8'h00);
        readCheck(8'hF3, 8'h00, "tctrl_disabled");
        readCheck(8'hF2, 8'h01, "timer_last_inc");
        tick();
        readCheck(8'hF2, 8'h01, "timer_held");

        // Asynchronous reset while the FIFO is draining with three entries left.
        tx_ready = 1'b0;
        doWrite(8'hF0, 8'hB1);
        doWrite(8'hF0, 8'hB2);
        doWrite(8'hF0, 8'hB3);
        doWrite(8'hF0, 8'hB4);
        doWrite(8'hF3, 8'h01);
        dataAddr = 8'hF1;
        tx_ready = 1'b1;
        tick();
        check("pre_reset_head", tx_data, 8'hB2);
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        check("async_rst_valid", {7'b0, tx_valid}, 8'h00);
        check("async_rst_status", dataIn, 8'h01);
        dataAddr = 8'hF2;
        #1;
        check("async_rst_timer", dataIn, 8'h00);
        reset    = 1'b0;
        tx_ready = 1'b0;
        readCheck(8'h10, 8'hA5, "ram_retained");

        // Unmapped address.
        readCheck(8'hF8, 8'h00, "unmapped_rd");
        doWrite(8'hF8, 8'hFF);
        readCheck(8'hF1, 8'h01, "unmapped_wr_status");
        readCheck(8'hF3, 8'h00, "unmapped_wr_tctrl");
        readCheck(8'hF2, 8'h00, "unmapped_wr_timer");
        readCheck(8'h10, 8'hA5, "unmapped_wr_ram");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: pick = 8'($urandom_range(0, 239));
                4, 5, 6:    pick = 8'hF0;
                7:          pick = 8'hF1 + 8'($urandom_range(0, 2));
                8:          pick = 8'($urandom_range(244, 255));
                default:    pick = 8'hF3;
            endcase
            dataAddr    = pick;
            dataOut     = 8'($urandom);
            writeEnable = 1'($urandom_range(0, 1));
            tx_ready    = ($urandom_range(0, 2) == 0);
            #1;
            checkAgainstModel("rnd");
            tick();
        end
        writeEnable = 1'b0;
        tx_ready    = 1'b0;
        dataAddr    = 8'hF1;
        #1;
        checkAgainstModel("rnd_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
